// File: rtl/fifo_access_arb_pkg.sv
// Shared types and defaults for the three-slot FIFO access arbiter.
// Slot order P0 -> P1 -> RD is also the round-robin order.
package fifo_arb_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 64;

    typedef enum logic [1:0] {
        SLOT_P0 = 2'd0,
        SLOT_P1 = 2'd1,
        SLOT_RD = 2'd2
    } slot_t;

    // Pointer moves to the slot after the one just granted.
    function automatic slot_t next_slot(input logic [2:0] gnt);
        if (gnt[0])      return SLOT_P1;
        else if (gnt[1]) return SLOT_RD;
        else             return SLOT_P0;
    endfunction
endpackage

// File: rtl/fifo_access_arb_if.sv
// Bundle of producer, consumer and FIFO-side signals for fifo_access_arb.
// slave = arbiter side, master = environment side.
interface fifo_access_arb_if
    import fifo_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic              req0, req1, rd_req;
    logic [DATA_W-1:0] data0, data1;
    logic              gnt0, gnt1, rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              fifo_push, fifo_pop;
    logic [DATA_W-1:0] fifo_datain, fifo_dataout;
    logic              fifo_almost_full, fifo_error;
    logic [LW-1:0]     level;
    logic              err_sticky;

    modport slave (
        input  req0, req1, rd_req, data0, data1, fifo_dataout, fifo_almost_full, fifo_error,
        output gnt0, gnt1, rd_gnt, rd_valid, rd_data, fifo_push, fifo_pop, fifo_datain,
               level, err_sticky
    );

    modport master (
        output req0, req1, rd_req, data0, data1, fifo_dataout, fifo_almost_full, fifo_error,
        input  gnt0, gnt1, rd_gnt, rd_valid, rd_data, fifo_push, fifo_pop, fifo_datain,
               level, err_sticky
    );
endinterface

// File: rtl/fifo_access_arb_rr_pick3.sv
// Combinational 3-way round-robin picker: searches from ptr upward,
// returns a one-hot grant (or zero when no request is set).
module rr_pick3
    import fifo_arb_pkg::*;
(
    input  logic [2:0] req,
    input  slot_t      ptr,
    output logic [2:0] gnt
);
    always_comb begin
        gnt = 3'b000;
        case (ptr)
            SLOT_P0: begin
                if (req[0])      gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
            SLOT_P1: begin
                if (req[1])      gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            default: begin
                if (req[2])      gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
        endcase
    end
endmodule

// File: rtl/fifo_access_arb.sv
// Round-robin arbiter granting two producers and one consumer access to a FIFO.
// Optional macro ARB_POP_PRIORITY_EN: pops win while the FIFO is almost full.
module fifo_access_arb
    import fifo_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input logic              clk,
    input logic              rst_n,
    fifo_access_arb_if.slave bus
);
    localparam int            LW      = $clog2(DEPTH) + 1;
    localparam logic [LW:0]   FULL_X  = (LW + 1)'(DEPTH);
    localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

    slot_t             ptr;
    logic              armed;
    logic [LW:0]       lvl_eff;
    logic [2:0]        req_mask, pick, gnt_sel;
    logic [DATA_W-1:0] din_sel;

    // Occupancy as it will be once the op issued this cycle lands, so an
    // in-flight push/pop is never double-counted against the limits.
    assign lvl_eff = {1'b0, bus.level} + {{LW{1'b0}}, bus.fifo_push}
                   - {{LW{1'b0}}, bus.fifo_pop};

    assign req_mask[0] = armed & bus.req0   & ~bus.gnt0   & (lvl_eff < FULL_X);
    assign req_mask[1] = armed & bus.req1   & ~bus.gnt1   & (lvl_eff < FULL_X);
    assign req_mask[2] = armed & bus.rd_req & ~bus.rd_gnt & (lvl_eff != '0);

    rr_pick3 u_pick (
        .req (req_mask),
        .ptr (ptr),
        .gnt (pick)
    );

`ifdef ARB_POP_PRIORITY_EN
    assign gnt_sel = (bus.fifo_almost_full && req_mask[2]) ? 3'b100 : pick;
`else
    assign gnt_sel = pick;
`endif

    assign din_sel = gnt_sel[0] ? bus.data0 : (gnt_sel[1] ? bus.data1 : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed           <= 1'b0;
            ptr             <= SLOT_P0;
            bus.gnt0        <= 1'b0;
            bus.gnt1        <= 1'b0;
            bus.rd_gnt      <= 1'b0;
            bus.fifo_push   <= 1'b0;
            bus.fifo_pop    <= 1'b0;
            bus.fifo_datain <= '0;
            bus.level       <= '0;
            bus.rd_valid    <= 1'b0;
            bus.rd_data     <= '0;
            bus.err_sticky  <= 1'b0;
        end else begin
            // One idle edge after reset release before arbitration opens.
            armed           <= 1'b1;
            bus.gnt0        <= gnt_sel[0];
            bus.gnt1        <= gnt_sel[1];
            bus.rd_gnt      <= gnt_sel[2];
            bus.fifo_push   <= gnt_sel[0] | gnt_sel[1];
            bus.fifo_pop    <= gnt_sel[2];
            bus.fifo_datain <= din_sel;
            if (|gnt_sel)
                ptr <= next_slot(gnt_sel);
            if (bus.fifo_push && bus.level != LVL_MAX)
                bus.level <= bus.level + LW'(1);
            else if (bus.fifo_pop && bus.level != '0)
                bus.level <= bus.level - LW'(1);
            bus.rd_valid <= bus.fifo_pop;
            if (bus.fifo_pop)
                bus.rd_data <= bus.fifo_dataout;
            if (bus.fifo_error)
                bus.err_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_access_arb.sv
// Directed bench for fifo_access_arb: vector table plus hand-written sequences
// for full FIFO, sticky error, reset mid-push and post-reset grant latency.
module tb_fifo_access_arb;
    typedef struct packed {
        logic        r0, r1, rd, af;
        logic [15:0] d0, d1;
        logic        g0, g1, gr, push, pop;
        logic [15:0] din;
        logic [6:0]  lvl;
        logic        rv;
        logic [15:0] rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];
    vec_t v;
    logic [15:0] q[$];

    always #5 clk = ~clk;

    fifo_access_arb_if #(.DATA_W(16), .DEPTH(64)) bus ();

    fifo_access_arb #(.DATA_W(16), .DEPTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Show-ahead FIFO model: head word is presented on fifo_dataout.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            bus.fifo_dataout <= '0;
        end else begin
            if (bus.fifo_push) q.push_back(bus.fifo_datain);
            if (bus.fifo_pop && q.size() > 0) void'(q.pop_front());
            bus.fifo_dataout <= (q.size() > 0) ? q[0] : 16'h0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic addv(input logic r0, r1, rd, af, input logic [15:0] d0, d1,
                        input logic g0, g1, gr, push, pop, input logic [15:0] din,
                        input logic [6:0] lvl, input logic rv, input logic [15:0] rdata);
        vec_t t;
        t = '{r0:r0, r1:r1, rd:rd, af:af, d0:d0, d1:d1, g0:g0, g1:g1, gr:gr,
              push:push, pop:pop, din:din, lvl:lvl, rv:rv, rdata:rdata};
        tbl.push_back(t);
    endtask

    task automatic drive_idle();
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.rd_req = 1'b0;
        bus.data0 = '0; bus.data1 = '0;
        bus.fifo_almost_full = 1'b0; bus.fifo_error = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " gnt0"}, bus.gnt0, 0);
        chk({tag, " gnt1"}, bus.gnt1, 0);
        chk({tag, " rd_gnt"}, bus.rd_gnt, 0);
        chk({tag, " push"}, bus.fifo_push, 0);
        chk({tag, " pop"}, bus.fifo_pop, 0);
        chk({tag, " datain"}, bus.fifo_datain, 0);
        chk({tag, " level"}, bus.level, 0);
        chk({tag, " rd_valid"}, bus.rd_valid, 0);
        chk({tag, " rd_data"}, bus.rd_data, 0);
        chk({tag, " err"}, bus.err_sticky, 0);
    endtask

    initial begin
        int n;
        drive_idle();

        // Reads against an empty FIFO right after reset.
        for (int i = 0; i < 10; i++) addv(0,0,1,0, 0,0, 0,0,0,0,0, 0, 0, 0,0);
        addv(1,0,0,0, 1,0,      1,0,0,1,0, 1,     0, 0,0);
        addv(0,0,0,0, 0,0,      0,0,0,0,0, 0,     1, 0,0);
        addv(0,1,0,0, 0,2,      0,1,0,1,0, 2,     1, 0,0);
        addv(1,0,0,0, 3,0,      1,0,0,1,0, 3,     2, 0,0);
        addv(0,0,1,0, 0,0,      0,0,1,0,1, 0,     3, 0,0);
        addv(0,0,0,0, 0,0,      0,0,0,0,0, 0,     2, 1,1);
        // All three held together: P0, P1, RD on consecutive cycles.
        addv(1,1,1,0, 'hA,'hB,  1,0,0,1,0, 'hA,   2, 0,0);
        addv(0,1,1,0, 0,'hB,    0,1,0,1,0, 'hB,   3, 0,0);
        addv(0,0,1,0, 0,0,      0,0,1,0,1, 0,     4, 0,0);
        addv(0,0,0,0, 0,0,      0,0,0,0,0, 0,     3, 1,2);
        // Requester still high in its grant cycle must not be granted twice.
        addv(1,0,0,0, 5,0,      1,0,0,1,0, 5,     3, 0,0);
        addv(1,0,0,0, 5,0,      0,0,0,0,0, 0,     4, 0,0);
        addv(0,0,0,0, 0,0,      0,0,0,0,0, 0,     4, 0,0);
`ifdef ARB_POP_PRIORITY_EN
        addv(1,1,1,1, 6,7,      0,0,1,0,1, 0,     4, 0,0);
        addv(1,1,0,1, 6,7,      1,0,0,1,0, 6,     3, 1,3);
        addv(0,1,0,1, 0,7,      0,1,0,1,0, 7,     4, 0,0);
        addv(0,0,0,0, 0,0,      0,0,0,0,0, 0,     5, 0,0);
`else
        addv(1,1,1,1, 6,7,      0,1,0,1,0, 7,     4, 0,0);
        addv(1,0,1,1, 6,0,      0,0,1,0,1, 0,     5, 0,0);
        addv(1,0,0,1, 6,0,      1,0,0,1,0, 6,     4, 1,3);
        addv(0,0,0,0, 0,0,      0,0,0,0,0, 0,     5, 0,0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            v = tbl[i];
            bus.req0 = v.r0; bus.req1 = v.r1; bus.rd_req = v.rd;
            bus.data0 = v.d0; bus.data1 = v.d1; bus.fifo_almost_full = v.af;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d gnt0", i), bus.gnt0, v.g0);
            chk($sformatf("v%0d gnt1", i), bus.gnt1, v.g1);
            chk($sformatf("v%0d rd_gnt", i), bus.rd_gnt, v.gr);
            chk($sformatf("v%0d push", i), bus.fifo_push, v.push);
            chk($sformatf("v%0d pop", i), bus.fifo_pop, v.pop);
            chk($sformatf("v%0d datain", i), bus.fifo_datain, v.din);
            chk($sformatf("v%0d level", i), bus.level, v.lvl);
            chk($sformatf("v%0d rd_valid", i), bus.rd_valid, v.rv);
            if (v.rv) chk($sformatf("v%0d rd_data", i), bus.rd_data, v.rdata);
        end
        drive_idle();

        // Sticky error.
        bus.fifo_error = 1'b1;
        @(posedge clk); #1;
        bus.fifo_error = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("err_sticky", bus.err_sticky, 1);
            @(posedge clk); #1;
        end

        // Reset dropped while a push is on the FIFO strobes.
        bus.req0 = 1'b1; bus.data0 = 16'h55;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.gnt0 && n < 10);
        chk("midpush push", bus.fifo_push, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        bus.req0 = 1'b0;

        // First grant no earlier than the second edge after release.
        @(negedge clk);
        bus.req0 = 1'b1; bus.data0 = 16'h77;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel edge1 gnt0", bus.gnt0, 0);
        @(posedge clk); #1;
        chk("rel edge2 gnt0", bus.gnt0, 1);
        chk("rel edge2 datain", bus.fifo_datain, 16'h77);
        bus.req0 = 1'b0;
        @(posedge clk); #1;
        chk("rel level", bus.level, 1);

        // Fill to DEPTH, confirm writes blocked, then read the oldest word.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 64; i++) begin
            bus.req0 = 1'b1; bus.data0 = 16'(i);
            n = 0;
            do begin @(posedge clk); #1; n++; end while (!bus.gnt0 && n < 10);
            chk($sformatf("fill gnt %0d", i), bus.gnt0, 1);
            bus.req0 = 1'b0;
        end
        @(posedge clk); #1;
        chk("full level", bus.level, 64);
        bus.req1 = 1'b1; bus.data1 = 16'd99;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("full gnt1", bus.gnt1, 0);
            chk("full push", bus.fifo_push, 0);
        end
        bus.req1 = 1'b0;
        bus.rd_req = 1'b1;
        @(posedge clk); #1;
        chk("full rd_gnt", bus.rd_gnt, 1);
        chk("full pop", bus.fifo_pop, 1);
        bus.rd_req = 1'b0;
        @(posedge clk); #1;
        chk("full rd_valid", bus.rd_valid, 1);
        chk("full rd_data", bus.rd_data, 1);
        chk("full level63", bus.level, 63);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
